// File: rtl/cmn_sram_fifo_ctrl_pkg.sv
// Shared constants and helpers for the SRAM-backed val/rdy FIFO controller.
package cmn_sram_fifo_ctrl_pkg;

  localparam int unsigned c_obuf_depth     = 2;
  localparam int unsigned c_obuf_cnt_nbits = $clog2(c_obuf_depth + 1);

  // Width of the occupancy count: SRAM entries plus the two output-buffer slots, inclusive.
  function automatic int unsigned count_nbits(input int unsigned n);
    return $clog2(n + 3);
  endfunction

endpackage

// File: rtl/cmn_sram_fifo_ctrl_obuf.sv
// Two-entry register queue that absorbs SRAM read latency in front of the consumer.
module cmn_sram_fifo_ctrl_obuf
  import cmn_sram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned p_msg_nbits = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [p_msg_nbits-1:0]      push_data,
  input  logic                        pop,
  output logic [p_msg_nbits-1:0]      head,
  output logic                        full,
  output logic                        empty,
  output logic [c_obuf_cnt_nbits-1:0] cnt
);

  logic [p_msg_nbits-1:0] entry0;
  logic [p_msg_nbits-1:0] entry1;
  logic                   pop_ok;
  logic                   push_ok;

  always_comb begin
    empty   = (cnt == '0);
    full    = (cnt == c_obuf_cnt_nbits'(c_obuf_depth));
    head    = entry0;
    pop_ok  = pop && !empty;
    // A push into a full queue is only accepted as pop-then-refill.
    push_ok = push && (!full || pop_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt == '0) entry0 <= push_data;
          else           entry1 <= push_data;
          cnt <= cnt + c_obuf_cnt_nbits'(1);
        end
        2'b01: begin
          entry0 <= entry1;
          cnt    <= cnt - c_obuf_cnt_nbits'(1);
        end
        2'b11: begin
          if (cnt == c_obuf_cnt_nbits'(1)) begin
            entry0 <= push_data;
          end else begin
            entry0 <= entry1;
            entry1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cmn_sram_fifo_ctrl.sv
// Val/rdy FIFO controller using an external 1rw synchronous SRAM as storage.
// Define CMN_SRAM_FIFO_CTRL_COUNT_EN to expose the occupancy count port.
module cmn_sram_fifo_ctrl
  import cmn_sram_fifo_ctrl_pkg::*;
#(
  parameter  int unsigned p_msg_nbits   = 32,
  parameter  int unsigned p_num_entries = 16,
  localparam int unsigned c_addr_nbits  = $clog2(p_num_entries),
  localparam int unsigned c_data_nbytes = (p_msg_nbits + 7) / 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     recv_val,
  output logic                     recv_rdy,
  input  logic [p_msg_nbits-1:0]   recv_msg,
  output logic                     send_val,
  input  logic                     send_rdy,
  output logic [p_msg_nbits-1:0]   send_msg,
  output logic                     sram_read_en,
  output logic [c_addr_nbits-1:0]  sram_read_addr,
  input  logic [p_msg_nbits-1:0]   sram_read_data,
  output logic                     sram_write_en,
  output logic [c_data_nbytes-1:0] sram_write_byte_en,
  output logic [c_addr_nbits-1:0]  sram_write_addr,
`ifdef CMN_SRAM_FIFO_CTRL_COUNT_EN
  output logic [p_msg_nbits-1:0]   sram_write_data,
  output logic [count_nbits(p_num_entries)-1:0] count
`else
  output logic [p_msg_nbits-1:0]   sram_write_data
`endif
);

  localparam int unsigned c_cnt_nbits = $clog2(p_num_entries + 1);
  localparam logic [c_addr_nbits-1:0] c_last_addr = c_addr_nbits'(p_num_entries - 1);
  localparam logic [c_cnt_nbits-1:0]  c_full_cnt  = c_cnt_nbits'(p_num_entries);

  logic [c_addr_nbits-1:0]     wr_ptr;
  logic [c_addr_nbits-1:0]     rd_ptr;
  logic [c_cnt_nbits-1:0]      sram_cnt;
  logic                        inflight;

  logic [c_obuf_cnt_nbits-1:0] obuf_cnt;
  logic                        obuf_full;
  logic                        obuf_empty;
  logic                        obuf_push;
  logic [p_msg_nbits-1:0]      obuf_push_data;

  logic rd_issue;
  logic bypass;
  logic recv_xfer;
  logic send_xfer;
  logic wr_issue;

  function automatic logic [c_addr_nbits-1:0] ptr_inc(input logic [c_addr_nbits-1:0] p);
    return (p == c_last_addr) ? '0 : p + c_addr_nbits'(1);
  endfunction

  always_comb begin
    // Reads are issued from registered state only, so a read never depends on send_rdy.
    rd_issue  = (sram_cnt != '0) &&
                ((c_obuf_cnt_nbits'(inflight) + obuf_cnt) < c_obuf_cnt_nbits'(c_obuf_depth));
    bypass    = (sram_cnt == '0) && !inflight && !rd_issue && !obuf_full;
    recv_rdy  = !reset && !rd_issue && (bypass || (sram_cnt < c_full_cnt));
    recv_xfer = recv_val && recv_rdy;
    wr_issue  = recv_xfer && !bypass;

    send_val  = !obuf_empty;
    send_xfer = send_val && send_rdy;

    // Bypass requires !inflight, so the two push sources are mutually exclusive.
    obuf_push      = inflight || (recv_xfer && bypass);
    obuf_push_data = inflight ? sram_read_data : recv_msg;

    sram_read_en       = rd_issue && !reset;
    sram_read_addr     = rd_ptr;
    sram_write_en      = wr_issue;
    sram_write_addr    = wr_ptr;
    sram_write_byte_en = {c_data_nbytes{wr_issue}};
    sram_write_data    = recv_msg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sram_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= sram_read_en;
      if (sram_read_en) rd_ptr <= ptr_inc(rd_ptr);
      if (wr_issue)     wr_ptr <= ptr_inc(wr_ptr);
      case ({wr_issue, sram_read_en})
        2'b10:   sram_cnt <= sram_cnt + c_cnt_nbits'(1);
        2'b01:   sram_cnt <= sram_cnt - c_cnt_nbits'(1);
        default: ;
      endcase
    end
  end

  cmn_sram_fifo_ctrl_obuf #(
    .p_msg_nbits (p_msg_nbits)
  ) u_obuf (
    .clk       (clk),
    .reset     (reset),
    .push      (obuf_push),
    .push_data (obuf_push_data),
    .pop       (send_xfer),
    .head      (send_msg),
    .full      (obuf_full),
    .empty     (obuf_empty),
    .cnt       (obuf_cnt)
  );

`ifdef CMN_SRAM_FIFO_CTRL_COUNT_EN
  localparam int unsigned c_count_nbits = count_nbits(p_num_entries);
  assign count = c_count_nbits'(sram_cnt) + c_count_nbits'(inflight) + c_count_nbits'(obuf_cnt);
`endif

endmodule

// File: tb/tb_cmn_sram_fifo_ctrl.sv
// Self-checking bench: controller paired with a behavioural 1rw SRAM, checked against a queue model.
module tb_cmn_sram_fifo_ctrl;
  import cmn_sram_fifo_ctrl_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned NB = (W + 7) / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          recv_val = 1'b0;
  logic          recv_rdy;
  logic [W-1:0]  recv_msg = '0;
  logic          send_val;
  logic          send_rdy = 1'b0;
  logic [W-1:0]  send_msg;
  logic          sram_read_en;
  logic [AW-1:0] sram_read_addr;
  logic [W-1:0]  sram_read_data;
  logic          sram_write_en;
  logic [NB-1:0] sram_write_byte_en;
  logic [AW-1:0] sram_write_addr;
  logic [W-1:0]  sram_write_data;
`ifdef CMN_SRAM_FIFO_CTRL_COUNT_EN
  logic [count_nbits(N)-1:0] count;
`endif

  always #5 clk = ~clk;

  cmn_sram_fifo_ctrl #(
    .p_msg_nbits   (W),
    .p_num_entries (N)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .recv_val           (recv_val),
    .recv_rdy           (recv_rdy),
    .recv_msg           (recv_msg),
    .send_val           (send_val),
    .send_rdy           (send_rdy),
    .send_msg           (send_msg),
    .sram_read_en       (sram_read_en),
    .sram_read_addr     (sram_read_addr),
    .sram_read_data     (sram_read_data),
    .sram_write_en      (sram_write_en),
    .sram_write_byte_en (sram_write_byte_en),
    .sram_write_addr    (sram_write_addr),
`ifdef CMN_SRAM_FIFO_CTRL_COUNT_EN
    .sram_write_data    (sram_write_data),
    .count              (count)
`else
    .sram_write_data    (sram_write_data)
`endif
  );

  // Behavioural 1rw synchronous SRAM with one-cycle read latency.
  logic [W-1:0] mem [N];
  always @(posedge clk) begin
    if (sram_read_en) sram_read_data <= mem[sram_read_addr];
    if (sram_write_en)
      for (int b = 0; b < int'(NB); b++)
        if (sram_write_byte_en[b]) mem[sram_write_addr][8*b +: 8] <= sram_write_data[8*b +: 8];
  end

  int n_checks = 0;
  int n_errs   = 0;
  logic [W-1:0] model_q[$];
  int exp_waddr = 0;
  int exp_raddr = 0;
  int wr_seen = 0;
  int pops = 0;
  int rd_with_val = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle at the negedge, sample before the next posedge, update the model.
  task automatic step(input logic rst, input logic rv, input logic [W-1:0] m, input logic sr);
    @(negedge clk);
    reset = rst; recv_val = rv; recv_msg = m; send_rdy = sr;
    #1;
    if (sram_read_en || sram_write_en)
      check("rw_excl", 64'(sram_read_en && sram_write_en), 64'd0);
`ifdef CMN_SRAM_FIFO_CTRL_COUNT_EN
    check("count", 64'(count), 64'(model_q.size()));
`endif
    if (sram_write_en) begin
      check("wr_addr", 64'(sram_write_addr), 64'(exp_waddr));
      check("wr_ben", 64'(sram_write_byte_en), 64'({NB{1'b1}}));
      check("wr_data", 64'(sram_write_data), 64'(m));
      exp_waddr = (exp_waddr + 1) % N;
      wr_seen++;
    end
    if (sram_read_en) begin
      check("rd_addr", 64'(sram_read_addr), 64'(exp_raddr));
      check("rd_blocks_wr", 64'(recv_rdy), 64'd0);
      exp_raddr = (exp_raddr + 1) % N;
      if (rv) rd_with_val++;
    end
    if (send_val && sr) begin
      if (model_q.size() == 0) check("send_spurious", 64'(send_val), 64'd0);
      else                     check("send_msg", 64'(send_msg), 64'(model_q.pop_front()));
      pops++;
    end
    if (rv && recv_rdy) model_q.push_back(m);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step(1'b1, 1'b0, '0, 1'b0);
      check("rst_rdy", 64'(recv_rdy), 64'd0);
    end
    model_q.delete();
    exp_waddr = 0;
    exp_raddr = 0;
  endtask

  task automatic push_msg(input logic [W-1:0] m, input logic sr);
    int k = 0;
    bit done = 0;
    while (!done && k < 20) begin
      step(1'b0, 1'b1, m, sr);
      done = recv_rdy;
      k++;
    end
    if (!done) check("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while (model_q.size() > 0 && k < bound) begin
      step(1'b0, 1'b0, '0, 1'b1);
      k++;
    end
    check("drain_empty", 64'(model_q.size()), 64'd0);
    step(1'b0, 1'b0, '0, 1'b1);
    check("drain_sendval", 64'(send_val), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] pend;
    int sent;
    int k;
    bit seen;

    // 1: reset then idle
    do_reset(2);
    step(1'b0, 1'b0, '0, 1'b0);
    check("idle_sendval", 64'(send_val), 64'd0);
    check("idle_rdy", 64'(recv_rdy), 64'd1);
    check("idle_rd_en", 64'(sram_read_en), 64'd0);
    check("idle_wr_en", 64'(sram_write_en), 64'd0);

    // 2: bypass, latency one cycle, no SRAM write
    wr_seen = 0;
    step(1'b0, 1'b1, 32'hA, 1'b1);
    check("byp_rdy", 64'(recv_rdy), 64'd1);
    check("byp_val_lat", 64'(send_val), 64'd0);
    step(1'b0, 1'b0, '0, 1'b1);
    check("byp_val", 64'(send_val), 64'd1);
    check("byp_msg", 64'(send_msg), 64'hA);
    step(1'b0, 1'b0, '0, 1'b1);
    check("byp_nowrite", 64'(wr_seen), 64'd0);

    // 3: fill to capacity with consumer stalled, then drain in order
    do_reset(1);
    wr_seen = 0;
    for (int i = 1; i <= 6; i++) push_msg(W'(i), 1'b0);
    step(1'b0, 1'b1, 32'h99, 1'b0);
    check("full_rdy", 64'(recv_rdy), 64'd0);
    check("full_writes", 64'(wr_seen), 64'd4);
    check("full_occ", 64'(model_q.size()), 64'd6);
    pops = 0;
    drain(60);
    check("fill_pops", 64'(pops), 64'd6);

    // 4: random val/rdy traffic across pointer wrap
    do_reset(1);
    pops = 0;
    sent = 0;
    k = 0;
    pend = $urandom();
    while ((sent < 20 || model_q.size() > 0) && k < 2000) begin
      logic rv;
      rv = (sent < 20) && ($urandom_range(0, 1) == 1);
      step(1'b0, rv, pend, $urandom_range(0, 2) != 0);
      if (rv && recv_rdy) begin
        sent++;
        pend = $urandom();
      end
      k++;
    end
    check("rand_pops", 64'(pops), 64'd20);
    drain(10);

    // 5: obuf full, SRAM holds 2, producer and consumer both steady
    do_reset(1);
    for (int i = 0; i < 4; i++) push_msg(W'(32'h50 + i), 1'b0);
    rd_with_val = 0;
    pend = 32'h60;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, pend, 1'b1);
      if (recv_rdy) pend = pend + 1;
    end
    check("simul_rd_prio", 64'(rd_with_val > 0), 64'd1);
    drain(60);

    // 6: reset the cycle after a read is issued
    do_reset(1);
    for (int i = 0; i < 6; i++) push_msg(W'(32'hC0 + i), 1'b0);
    seen = 0;
    k = 0;
    while (!seen && k < 10) begin
      step(1'b0, 1'b0, '0, 1'b1);
      seen = sram_read_en;
      k++;
    end
    check("mid_rd_seen", 64'(seen), 64'd1);
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      check("post_rst_val", 64'(send_val), 64'd0);
    end
    check("post_rst_rdy", 64'(recv_rdy), 64'd1);
    push_msg(32'h77, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    check("post_rst_msg", 64'(send_msg), 64'h77);
    drain(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
